// File: rtl/newsstand_vend.sv
// Newspaper vending controller: coin credit accumulator, single-cycle vend,
// nickel-at-a-time change/refund, and a stock counter with sold-out lockout.
module newsstand_vend #(
    parameter int PRICE       = 15,
    parameter int STOCK_DEPTH = 8,
    parameter int CREDIT_W    = 8,
    parameter int STOCK_W     = $clog2(STOCK_DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [2:0]          coin,
    input  logic                cancel,
    input  logic                restock,
    output logic                newspaper,
    output logic                change,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock,
    output logic                sold_out
);

    typedef enum logic [1:0] {COLLECT, VEND, RETURN} state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(5);
    localparam logic [STOCK_W-1:0]  FULL_C   = STOCK_W'(STOCK_DEPTH);

    state_t              state, state_nx;
    logic [CREDIT_W-1:0] credit_nx;
    logic [STOCK_W-1:0]  stock_nx;
    logic                reject_nx;
    logic [CREDIT_W-1:0] coin_value;
    logic                coin_valid;

    // Codes 4..7 have bit 2 set and are never worth anything.
    assign coin_valid = (coin != 3'd0) && !coin[2];

    always_comb begin
        case (coin)
            3'd1:    coin_value = CREDIT_W'(5);
            3'd2:    coin_value = CREDIT_W'(10);
            3'd3:    coin_value = CREDIT_W'(25);
            default: coin_value = '0;
        endcase
    end

    always_comb begin
        state_nx  = state;
        credit_nx = credit;
        stock_nx  = stock;
        reject_nx = 1'b0;
        case (state)
            COLLECT: begin
                if (cancel && credit != '0) begin
                    state_nx  = RETURN;
                    reject_nx = (coin != 3'd0);
                end else if (coin_valid && stock != '0) begin
                    credit_nx = credit + coin_value;
                    if (credit_nx >= PRICE_C)
                        state_nx = VEND;
                end else if (coin != 3'd0) begin
                    reject_nx = 1'b1;
                end
            end
            VEND: begin
                credit_nx = credit - PRICE_C;
                if (stock != '0)
                    stock_nx = stock - STOCK_W'(1);
                state_nx  = (credit_nx != '0) ? RETURN : COLLECT;
                reject_nx = (coin != 3'd0);
            end
            RETURN: begin
                credit_nx = credit - NICKEL_C;
                if (credit == NICKEL_C)
                    state_nx = COLLECT;
                reject_nx = (coin != 3'd0);
            end
            default: state_nx = COLLECT;
        endcase
        // Restock wins over the vend decrement on the same edge.
        if (restock)
            stock_nx = FULL_C;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= COLLECT;
            credit      <= '0;
            stock       <= FULL_C;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_nx;
            credit      <= credit_nx;
            stock       <= stock_nx;
            coin_reject <= reject_nx;
        end
    end

    assign newspaper = (state == VEND);
    assign change    = (state == RETURN);
    assign sold_out  = (stock == '0);

endmodule

// File: doc/newsstand_vend.md
# newsstand_vend

Parametrised newspaper vending controller, successor to the fixed 15-cent newsstand FSM. Accepts nickels, dimes and quarters into a credit accumulator, vends when credit reaches a configurable price, returns change one nickel per cycle, supports customer cancel/refund, and tracks an inventory counter with sold-out lockout. Sits between the coin acceptor front end and the paper-release and change-hopper actuators.

## Interface

- PRICE, 15: paper price in cents; multiple of 5, range 5..200.
- STOCK_DEPTH, 8: papers loaded at reset and on restock; ≥1.
- CREDIT_W, 8: credit register width; must hold PRICE+20.
- STOCK_W, $clog2(STOCK_DEPTH+1): stock counter width; derived, do not override.

- clock  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- coin  in  3  coin code, sampled each edge: 0 none, 1 nickel (5), 2 dime (10), 3 quarter (25), 4..7 invalid.
- cancel  in  1  level, sampled each edge: refund all credit.
- restock  in  1  sampled each edge: reload stock to STOCK_DEPTH.
- newspaper  out  1  one-cycle release pulse.
- change  out  1  one nickel returned per high cycle.
- coin_reject  out  1  one-cycle pulse, the coin presented on the previous edge was returned.
- credit  out  CREDIT_W  current credit in cents.
- stock  out  STOCK_W  papers remaining.
- sold_out  out  1  high when stock == 0.

## Operation

- States: COLLECT, VEND, RETURN. Reset → COLLECT, credit 0, stock STOCK_DEPTH, newspaper/change/coin_reject 0, sold_out 0.
- COLLECT:
  - cancel && credit > 0 → RETURN; any coin this edge rejected.
  - cancel && credit == 0 → ignored; a coin on the same edge is still processed normally.
  - valid coin, stock > 0: credit ← credit + value; if the new credit ≥ PRICE → VEND, else stay.
  - valid coin with stock == 0, or invalid code 4..7 → reject; credit unchanged.
- VEND (exactly one cycle): newspaper = 1; credit ← credit − PRICE; stock ← stock − 1; → RETURN if remainder > 0, else COLLECT.
- RETURN: change = 1 every cycle; credit ← credit − 5; → COLLECT on the edge where credit goes 5 → 0.
- Any nonzero coin arriving in VEND or RETURN is rejected.
- newspaper and change are decoded from the state register. No combinational input-to-output path.
- coin_reject is registered. It is high in the cycle after the rejected coin was sampled.
- restock: stock ← STOCK_DEPTH at the next edge in any state. It takes priority over the VEND decrement on the same edge.
- sold_out = (stock == 0). It does not abort an in-progress VEND or RETURN.
- Credit never exceeds PRICE+20; there is no overflow path.

## Timing

- Coin completing the price at edge N: newspaper is high from edge N to edge N+1.
- The first change pulse is high from N+1 to N+2. Change pulses are contiguous, count = (credit − PRICE)/5.
- Cancel sampled at edge N: change is high from edge N for credit/5 cycles. credit reaches 0 and state returns to COLLECT after the last pulse.
- New coins are accepted on the first edge back in COLLECT.
- reset_n assertion mid-VEND or mid-RETURN: all state clears immediately. Outstanding change is forfeited and stock returns to STOCK_DEPTH.

## Test plan

- PRICE=15, nickel then dime → credit 5, 15. newspaper is pulsed once with no change, stock goes 8→7, and the FSM returns to COLLECT.
- Quarter at PRICE=15 → newspaper 1 cycle, then 2 consecutive change pulses, credit goes 10→5→0, then COLLECT.
- Dime then cancel → 2 change pulses, no newspaper, stock unchanged. A nickel presented with the cancel gets coin_reject the next cycle.
- Eight vends from reset → sold_out = 1. The 9th coin is rejected with credit 0. Then restock → stock 8, sold_out 0, and the next coin is accepted.
- Coin codes 4..7, and a dime during RETURN → coin_reject each time, credit unaffected.
- reset_n low during RETURN with credit 10 → change 0, credit 0, stock STOCK_DEPTH, state COLLECT immediately. Also repeat the vend scenario with PRICE=35 and a dime plus quarter to confirm exact vend with no change.
